// File: rtl/rom_arbiter_pkg.sv
// Shared types and default widths for the ROM arbiter.
// The optional DMA fairness bound is enabled with ROM_ARBITER_FAIR_EN.
package rom_arbiter_pkg;

    localparam int ROM_ADDR_W = 12;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/rom_arbiter_rdpipe.sv
// Two-stage owner tag that follows each ROM slot through the registered
// address and the ROM's registered output, steering the returning valid.
module rom_arbiter_rdpipe
    import rom_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  owner_t owner_p0,
    output logic   cpu_rvalid,
    output logic   dma_rvalid,
    output logic   dma_inflight_p1
);

    owner_t tag_p1;
    owner_t tag_p2;

    // Shift the slot owner along with the read; reset flushes in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_p1 <= OWN_NONE;
            tag_p2 <= OWN_NONE;
        end else begin
            tag_p1 <= owner_p0;
            tag_p2 <= tag_p1;
        end
    end

    assign cpu_rvalid      = (tag_p2 == OWN_CPU);
    assign dma_rvalid      = (tag_p2 == OWN_DMA);
    assign dma_inflight_p1 = (tag_p1 == OWN_DMA);

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates one synchronous-read ROM between CPU single reads (priority)
// and a DMA burst reader. Define ROM_ARBITER_FAIR_EN to bound DMA starvation
// to STARVE_MAX consecutive lost slots.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int DATA_W     = ROM_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_start,
    input  logic [ADDR_W-1:0] dma_base,
    input  logic [ADDR_W:0]   dma_len,
    output logic              dma_busy,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W:0]   remaining, remaining_nxt;
    logic [ADDR_W-1:0] rom_addr_nxt;
    logic              zero_done_p1, zero_done_nxt;
    owner_t            owner_p0;
    logic              dma_elig;
    logic              force_dma;
    logic              drain_done;
    logic              dma_inflight_p1;

    assign dma_elig = (state == RUN) && (remaining != '0);

`ifdef ROM_ARBITER_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    // Count consecutive slots DMA was eligible for but lost to the CPU
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (owner_p0 == OWN_DMA) begin
            starve_cnt <= '0;
        end else if (dma_elig) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    assign force_dma = dma_elig && (starve_cnt == CNT_W'(STARVE_MAX));
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = (STARVE_MAX == 0);
    assign force_dma = 1'b0;
`endif

    // Pick the slot owner and compute FSM, pointer and ROM address updates
    always_comb begin
        owner_p0      = OWN_NONE;
        state_nxt     = state;
        ptr_nxt       = ptr;
        remaining_nxt = remaining;
        rom_addr_nxt  = rom_addr;
        zero_done_nxt = 1'b0;

        if (cpu_req && !force_dma) begin
            owner_p0 = OWN_CPU;
        end else if (dma_elig) begin
            owner_p0 = OWN_DMA;
        end

        case (owner_p0)
            OWN_CPU: rom_addr_nxt = cpu_addr;
            OWN_DMA: rom_addr_nxt = ptr;
            default: rom_addr_nxt = rom_addr;
        endcase

        case (state)
            IDLE: begin
                if (dma_start) begin
                    if (dma_len != '0) begin
                        ptr_nxt       = dma_base;
                        remaining_nxt = dma_len;
                        state_nxt     = RUN;
                    end else begin
                        zero_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (owner_p0 == OWN_DMA) begin
                    ptr_nxt       = ptr + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == (ADDR_W + 1)'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, burst pointer, word count and ROM address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            remaining    <= '0;
            rom_addr     <= '0;
            zero_done_p1 <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            remaining    <= remaining_nxt;
            rom_addr     <= rom_addr_nxt;
            zero_done_p1 <= zero_done_nxt;
        end
    end

    rom_arbiter_rdpipe u_rdpipe (
        .clk             (clk),
        .rst             (rst),
        .owner_p0        (owner_p0),
        .cpu_rvalid      (cpu_rvalid),
        .dma_rvalid      (dma_rvalid),
        .dma_inflight_p1 (dma_inflight_p1)
    );

    // The last DMA word returns when no further DMA read is behind it
    assign drain_done = (state == DRAIN) && dma_rvalid && !dma_inflight_p1;

    assign cpu_gnt   = cpu_req && (owner_p0 == OWN_CPU);
    assign dma_busy  = (state != IDLE);
    assign dma_done  = drain_done || zero_done_p1;
    assign cpu_rdata = cpu_rvalid ? rom_dout : '0;
    assign dma_rdata = dma_rvalid ? rom_dout : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized bench for rom_arbiter against a transaction-level model:
// grants, returned data per requester, burst address order, done/busy timing.
module tb_rom_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SM = 8;
`ifdef ROM_ARBITER_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dma_start;
    logic [AW-1:0] dma_base;
    logic [AW:0]   dma_len;
    logic          dma_busy;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          dma_done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_start  (dma_start),
        .dma_base   (dma_base),
        .dma_len    (dma_len),
        .dma_busy   (dma_busy),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_done   (dma_done),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // ROM with one cycle of registered read latency
    always @(posedge clk) rom_dout <= rom_val(rom_addr);

    typedef struct {
        int            due;
        bit            is_dma;
        logic [AW-1:0] addr;
    } rd_t;

    rd_t           pend[$];
    logic [AW-1:0] dma_q[$];
    bit            busy_m;
    int            done_due;
    int            starve;
    logic [AW-1:0] last_addr;
    int            now;
    bit            hold_req;
    logic [AW-1:0] hold_addr;
    int            n_chk;
    int            n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    // One clock: drive inputs after the edge, compare mid-cycle, advance the model
    task automatic step(input bit r, input bit req, input logic [AW-1:0] addr,
                        input bit st, input logic [AW-1:0] base, input logic [AW:0] len);
        bit            elig, frc, exp_gnt, dslot, exp_cv, exp_dv, exp_done, start_ok;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] a;
        rd_t           e;
        @(posedge clk);
        #1;
        if (hold_req && !r) begin
            req  = 1'b1;
            addr = hold_addr;
        end
        rst = r; cpu_req = req; cpu_addr = addr;
        dma_start = st; dma_base = base; dma_len = len;
        #4;
        now++;
        if (r) begin
            pend.delete();
            dma_q.delete();
            busy_m = 0; done_due = -1; starve = 0; last_addr = '0; hold_req = 0;
            return;
        end
        elig    = (dma_q.size() != 0);
        frc     = FAIR && elig && (starve == SM);
        exp_gnt = req && !frc;
        dslot   = elig && !exp_gnt;
        exp_cv = 0; exp_dv = 0; exp_data = '0;
        if (pend.size() != 0 && pend[0].due == now) begin
            e = pend.pop_front();
            exp_cv   = !e.is_dma;
            exp_dv   = e.is_dma;
            exp_data = rom_val(e.addr);
        end
        exp_done = (done_due == now);

        check("cpu_gnt", cpu_gnt, exp_gnt);
        check("cpu_rvalid", cpu_rvalid, exp_cv);
        check("dma_rvalid", dma_rvalid, exp_dv);
        if (exp_cv) check("cpu_rdata", cpu_rdata, exp_data);
        if (exp_dv) check("dma_rdata", dma_rdata, exp_data);
        check("dma_done", dma_done, exp_done);
        check("dma_busy", dma_busy, busy_m);
        check("rom_addr", rom_addr, last_addr);

        if (exp_gnt) begin
            pend.push_back('{now + 2, 1'b0, addr});
            last_addr = addr;
        end
        if (dslot) begin
            a = dma_q.pop_front();
            pend.push_back('{now + 2, 1'b1, a});
            last_addr = a;
            if (dma_q.size() == 0) done_due = now + 2;
        end
        if (dslot) starve = 0;
        else if (elig) starve++;
        else starve = 0;

        start_ok = st && !busy_m;
        if (exp_done) busy_m = 0;
        if (start_ok) begin
            if (len == '0) begin
                done_due = now + 1;
            end else begin
                for (int i = 0; i < int'(len); i++) dma_q.push_back(base + AW'(i));
                busy_m = 1;
            end
        end
        hold_req  = req && !exp_gnt;
        hold_addr = addr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0);
    endtask

    initial begin
        int guard;
        n_chk = 0; n_err = 0; now = 0;
        busy_m = 0; done_due = -1; starve = 0; last_addr = '0; hold_req = 0; hold_addr = '0;
        rst = 1; cpu_req = 0; cpu_addr = '0; dma_start = 0; dma_base = '0; dma_len = '0;

        // Reset and the first cycle after release
        for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, '0);
        step(0, 0, '0, 0, '0, '0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_dma_rdata", dma_rdata, 0);

        // CPU single read at 0x000
        step(0, 1, 12'h000, 0, '0, '0);
        idle(3);

        // Plain burst, wrapping burst, zero-length burst
        step(0, 0, '0, 1, 12'h010, 13'd4);
        idle(8);
        step(0, 0, '0, 1, 12'hFFE, 13'd4);
        idle(8);
        step(0, 0, '0, 1, 12'h055, 13'd0);
        idle(3);

        // CPU holds the bus during a 16-word burst
        step(0, 0, '0, 1, 12'h100, 13'd16);
        for (int i = 0; i < 40; i++) step(0, 1, AW'($urandom), 0, '0, '0);
        idle(30);

        // Alternating CPU traffic during a burst
        step(0, 0, '0, 1, 12'h200, 13'd20);
        for (int i = 0; i < 30; i++) step(0, i % 2 == 0, AW'($urandom), 0, '0, '0);
        idle(10);

        // Reset while reads are in flight, then a fresh burst
        step(0, 0, '0, 1, 12'h300, 13'd10);
        step(0, 0, '0, 0, '0, '0);
        step(0, 1, 12'h0AB, 0, '0, '0);
        step(0, 0, '0, 0, '0, '0);
        step(1, 0, '0, 0, '0, '0);
        step(0, 0, '0, 0, '0, '0);
        check("rst_mid_cpu_rdata", cpu_rdata, 0);
        check("rst_mid_dma_rdata", dma_rdata, 0);
        step(0, 0, '0, 1, 12'h020, 13'd5);
        idle(10);

        // Random mixed traffic including starts while busy
        for (int i = 0; i < 600; i++) begin
            logic [AW:0] l;
            l = ($urandom % 8 == 0) ? '0 : (AW + 1)'($urandom_range(1, 24));
            step(0, $urandom % 2 == 0, AW'($urandom), $urandom % 12 == 0, AW'($urandom), l);
        end

        // Full-depth burst with light CPU traffic
        idle(60);
        step(0, 0, '0, 1, 12'h123, 13'h1000);
        for (int i = 0; i < 5200; i++) step(0, $urandom % 10 < 3, AW'($urandom), 0, '0, '0);

        guard = 0;
        while ((busy_m || pend.size() != 0 || done_due >= now) && guard < 6000) begin
            idle(1);
            guard++;
        end
        if (guard >= 6000) check("drain_timeout", 1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares one 4 KiB synchronous-read ROM between two requesters: the 6502 CPU (single reads) and a DMA burst reader (e.g. copy/checksum engine).
- The ROM has a registered output with 1-cycle read latency. It sits between the CPU bus decode and the ROM instance in the top level.
- The CPU has priority. DMA uses idle slots, with an optional starvation bound.
- Sustains one ROM read per clock.

Parameters:
- ADDR_W, 12, ROM address width (depth = 2**ADDR_W)
- DATA_W, 8, ROM data width
- STARVE_MAX, 8, max consecutive DMA slot losses before DMA is forced a slot (used only with fairness macro)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- cpu_req  input  1  CPU read request; hold with cpu_addr stable until cpu_gnt
- cpu_addr  input  ADDR_W  CPU read address
- cpu_gnt  output  1  combinational; request accepted this cycle
- cpu_rvalid  output  1  CPU read data valid (one-cycle pulse)
- cpu_rdata  output  DATA_W  CPU read data
- dma_start  input  1  start burst (pulse); ignored while dma_busy
- dma_base  input  ADDR_W  burst start address, sampled on dma_start
- dma_len  input  ADDR_W+1  word count 0..4096, sampled on dma_start
- dma_busy  output  1  burst in progress
- dma_rvalid  output  1  DMA read data valid
- dma_rdata  output  DATA_W  DMA read data, in address order
- dma_done  output  1  one-cycle pulse at burst end
- rom_addr  output  ADDR_W  registered address to ROM
- rom_dout  input  DATA_W  ROM registered data

Behaviour:
- Reset values:
  - All outputs 0; rom_addr = 0.
  - FSM in IDLE; counters 0; read pipeline flushed.
  - Reset mid-burst aborts the burst with no dma_done; in-flight data is discarded (no rvalid).
- Slot timing:
  - Cycle 0: slot granted, rom_addr <= granted address at the end of cycle 0.
  - Cycle 1: ROM samples the address.
  - Cycle 2: rom_dout valid. The matching rvalid is asserted in cycle 2, with rdata = rom_dout passed through.
  - Fixed latency: grant to rvalid = 2 cycles.
- Read pipeline: a 2-stage owner tag (NONE/CPU/DMA) steers each rvalid. cpu_rdata and dma_rdata both carry rom_dout; only the valid is steered.
- Slot owner per cycle:
  - CPU if cpu_req and not force_dma.
  - Else DMA if state == RUN and remaining != 0.
  - Else NONE; rom_addr holds its value.
- cpu_gnt = cpu_req and owner == CPU. Back-to-back CPU grants are allowed every cycle.
- FSM:
  - IDLE: dma_start with dma_len != 0 → latch base into ptr and len into remaining, go to RUN, dma_busy = 1. dma_start with dma_len == 0 → dma_done pulse next cycle, stay IDLE, no reads.
  - RUN: each DMA slot issues ptr, ptr++ (wraps modulo 2**ADDR_W, 0xFFF→0x000), remaining--. When the last word issues → DRAIN.
  - DRAIN: wait for the last DMA rvalid. dma_done is asserted in the same cycle as that rvalid, then IDLE; dma_busy drops the next cycle.
- dma_start while busy is ignored and has no effect on ptr or remaining.
- Simultaneous cpu_req and a DMA slot: CPU wins unless force_dma.
- A CPU request accepted during DRAIN or IDLE is unaffected by DMA state.

Optional Feature:
- Macro: ROM_ARBITER_FAIR_EN.
- Defined:
  - A starvation counter increments each RUN cycle in which DMA is eligible but loses to the CPU, and clears on any DMA slot.
  - When the count == STARVE_MAX, force_dma = 1 for the next slot: DMA is granted and cpu_gnt = 0 that cycle.
  - Guarantee: at most STARVE_MAX consecutive losses.
- Undefined: no counter, force_dma = 0, strict CPU priority; DMA may starve indefinitely.

Decomposition:
- Package rom_arbiter_pkg:
  - ADDR_W/DATA_W defaults.
  - typedef enum state_t {IDLE, RUN, DRAIN}.
  - typedef enum owner_t {OWN_NONE, OWN_CPU, OWN_DMA}.
- Sub-module rom_arbiter_rdpipe: 2-stage owner tag shift register with synchronous flush on rst; outputs cpu_rvalid/dma_rvalid.

Test Plan:
- CPU single read: cpu_req with addr 0x000 in cycle 0 → cpu_gnt in cycle 0; cpu_rvalid in cycle 2 with cpu_rdata = rom[0x000]; ROM preloaded with data = addr[7:0]^0xA5.
- DMA burst, no CPU traffic: base 0x010, len 4 → dma_rvalid in 4 consecutive cycles with rom[0x010..0x013] in order; dma_done coincides with the 4th rvalid; dma_busy low the following cycle.
- Wrap and zero length:
  - base 0xFFE, len 4 → data from 0xFFE, 0xFFF, 0x000, 0x001.
  - dma_len 0 → dma_done pulse one cycle after start; no rvalid; rom_addr unchanged.
- Contention: cpu_req held continuously during a 16-word burst.
  - Fair macro, STARVE_MAX = 8: DMA gets exactly one slot after every 8 CPU grants; the CPU sees cpu_gnt low in those cycles.
  - Without the macro: DMA issues nothing until cpu_req drops.
- Interleave: alternating CPU requests during a burst → every CPU read returns the correct data with its own rvalid; DMA order preserved; no rvalid is lost or duplicated.
- Reset mid-burst: rst asserted 2 cycles after a grant with reads in flight → the next cycle has all outputs 0, no rvalid or dma_done emitted; a new burst after release works normally.
